clkdiv_multi: RTL and testbench

Parametrised multi-channel clock divider for the 100 MHz board clock. Each of NCH independent channels produces a single-cycle enable pulse (`tick`) and a 50%-duty divided square wave (`clk_out`), with a runtime-programmable period. A new period takes effect glitch-free at the channel's next wrap. A global `sync` input phase-aligns all channels. It serves as the common source of pixel enables (25 MHz) and 7-segment scan clocks (381.47 Hz) for the display path.

---
 rtl/clkdiv_multi.sv | 98 +++++++++
 tb/tb_clkdiv_multi.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider: per-channel tick enable and 50% square wave.
// Period updates are deferred to the channel's next wrap; sync restarts all channels in phase.
module clkdiv_multi #(
  parameter int unsigned       NCH        = 2,
  parameter int unsigned       CW         = 18,
  parameter logic [NCH*CW-1:0] PERIOD_RST = {18'd131071, 18'd3},
  localparam int unsigned      ChW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           sync,
  input  logic           cfg_we,
  input  logic [ChW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  output logic [NCH-1:0] cfg_busy,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] clk_out
);

  logic [CW-1:0]  cnt_q    [NCH];
  logic [CW-1:0]  cnt_d    [NCH];
  logic [CW-1:0]  period_q [NCH];
  logic [CW-1:0]  period_d [NCH];
  logic [CW-1:0]  pval_q   [NCH];
  logic [CW-1:0]  pval_d   [NCH];
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] clk_out_q, clk_out_d;
  logic [NCH-1:0] we_hit;

  // Channel numbers >= NCH never match, so such writes fall through untouched.
  always_comb begin
    we_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_we && (cfg_ch == ChW'(i))) we_hit[i] = 1'b1;
    end
  end

  always_comb begin
    pend_d    = pend_q;
    tick_d    = '0;
    clk_out_d = clk_out_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]    = cnt_q[i];
      period_d[i] = period_q[i];
      pval_d[i]   = pval_q[i];
      if (sync || (cnt_q[i] == period_q[i])) begin
        // Wrap or phase restart: the only points where the period may change.
        cnt_d[i]  = '0;
        pend_d[i] = 1'b0;
        if (we_hit[i]) begin
          period_d[i] = cfg_period;
        end else if (pend_q[i]) begin
          period_d[i] = pval_q[i];
        end
        if (sync) begin
          clk_out_d[i] = 1'b0;
        end else begin
          tick_d[i]    = 1'b1;
          clk_out_d[i] = ~clk_out_q[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
        if (we_hit[i]) begin
          pval_d[i] = cfg_period;
          pend_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pend_q    <= '0;
      tick_q    <= '0;
      clk_out_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]    <= '0;
        period_q[i] <= PERIOD_RST[i*CW +: CW];
        pval_q[i]   <= '0;
      end
    end else begin
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        period_q[i] <= period_d[i];
        pval_q[i]   <= pval_d[i];
      end
    end
  end

  assign cfg_busy = pend_q;
  assign tick     = tick_q;
  assign clk_out  = clk_out_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: directed scenarios plus random traffic against an
// absolute-time reference model (each channel tracks the edge number of its next wrap).
module tb_clkdiv_multi;

  localparam int unsigned       NCH  = 3;
  localparam int unsigned       CW   = 18;
  localparam logic [NCH*CW-1:0] PRST = {18'd5, 18'd11, 18'd3};

  logic           clk = 1'b0;
  logic           clr, sync, cfg_we;
  logic [1:0]     cfg_ch;
  logic [CW-1:0]  cfg_period;
  logic [NCH-1:0] cfg_busy, tick, clk_out;

  clkdiv_multi #(
    .NCH        (NCH),
    .CW         (CW),
    .PERIOD_RST (PRST)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .sync       (sync),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_busy   (cfg_busy),
    .tick       (tick),
    .clk_out    (clk_out)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: edge count plus, per channel, the edge number of the next wrap.
  longint      t_m;
  longint      nxt_m  [NCH];
  int unsigned per_m  [NCH];
  int unsigned pval_m [NCH];
  bit          pend_m [NCH];
  bit          tick_m [NCH];
  bit          clko_m [NCH];

  function automatic int unsigned rst_per(input int i);
    logic [NCH*CW-1:0] v;
    v = PRST;
    return int'(v[i*CW +: CW]);
  endfunction

  task automatic model_edge(input bit c, input bit s, input bit w, input int ch,
                            input int unsigned p);
    t_m++;
    for (int i = 0; i < NCH; i++) begin
      bit hit;
      hit = w && (ch == i);
      if (c) begin
        per_m[i] = rst_per(i); pend_m[i] = 0; pval_m[i] = 0;
        tick_m[i] = 0; clko_m[i] = 0;
        nxt_m[i] = t_m + per_m[i] + 1;
      end else if (s || t_m == nxt_m[i]) begin
        if (hit) per_m[i] = p;
        else if (pend_m[i]) per_m[i] = pval_m[i];
        pend_m[i] = 0;
        tick_m[i] = !s;
        clko_m[i] = s ? 1'b0 : !clko_m[i];
        nxt_m[i] = t_m + per_m[i] + 1;
      end else begin
        tick_m[i] = 0;
        if (hit) begin
          pval_m[i] = p;
          pend_m[i] = 1;
        end
      end
    end
  endtask

  task automatic step(input bit c, input bit s, input bit w, input int ch, input int unsigned p);
    logic [NCH-1:0] et, ec, eb;
    logic [31:0] pv;
    pv = p;
    clr = c; sync = s; cfg_we = w; cfg_ch = 2'(ch); cfg_period = pv[CW-1:0];
    @(posedge clk);
    model_edge(c, s, w, ch, p & ((1 << CW) - 1));
    #1;
    for (int i = 0; i < NCH; i++) begin
      et[i] = tick_m[i]; ec[i] = clko_m[i]; eb[i] = pend_m[i];
    end
    check_eq("tick", 32'(tick), 32'(et));
    check_eq("clk_out", 32'(clk_out), 32'(ec));
    check_eq("cfg_busy", 32'(cfg_busy), 32'(eb));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  // Idle until tick[ch] is seen; n is the number of edges taken (limit if it never came).
  task automatic wait_tick(input int ch, input int limit, output int n);
    n = 0;
    do begin
      step(0, 0, 0, 0, 0);
      n++;
    end while (!tick[ch] && n < limit);
  endtask

  initial begin
    int n, busy_cnt, bad_align, t0_cnt, t1_cnt, guard;
    t_m = 0;
    clr = 1; sync = 0; cfg_we = 0; cfg_ch = 0; cfg_period = 0;

    // Reset defaults, first tick at the 4th edge after release.
    repeat (3) step(1, 0, 0, 0, 0);
    check_eq("rst_tick", 32'(tick), 0);
    check_eq("rst_clk_out", 32'(clk_out), 0);
    wait_tick(0, 10, n);
    check_eq("rst_first_tick0", n, 4);
    check_eq("rst_clk_out0_rise", 32'(clk_out[0]), 1);
    wait_tick(0, 10, n);
    check_eq("rst_tick0_gap", n, 4);
    wait_tick(2, 10, n);
    idle(6);

    // Glitch-free update: write 7 to ch0 while its cnt is 1.
    step(0, 1, 0, 0, 0);
    idle(1);
    step(0, 0, 1, 0, 7);
    busy_cnt = int'(cfg_busy[0]);
    n = 0;
    do begin
      step(0, 0, 0, 0, 0);
      n++;
      busy_cnt += int'(cfg_busy[0]);
    end while (!tick[0] && n < 10);
    check_eq("upd_old_period_end", n, 2);
    wait_tick(0, 20, n);
    check_eq("upd_busy_len", busy_cnt, 2);
    check_eq("upd_new_gap", n, 8);
    wait_tick(0, 20, n);
    check_eq("upd_new_gap2", n, 8);

    // Last write wins: 9 then 5 before the wrap.
    wait_tick(0, 20, n);
    step(0, 0, 1, 0, 9);
    step(0, 0, 1, 0, 5);
    wait_tick(0, 20, n);
    wait_tick(0, 20, n);
    check_eq("lww_gap", n, 6);

    // Write 2 exactly on a wrap edge: applied at once, no busy.
    guard = 0;
    while (t_m + 1 != nxt_m[0] && guard < 40) begin
      step(0, 0, 0, 0, 0);
      guard++;
    end
    step(0, 0, 1, 0, 2);
    check_eq("wrap_wr_busy", 32'(cfg_busy[0]), 0);
    check_eq("wrap_wr_tick", 32'(tick[0]), 1);
    wait_tick(0, 20, n);
    check_eq("wrap_wr_gap", n, 3);

    // Sync alignment: ch0 P=1, ch1 pending P=3 applied on the sync edge.
    step(0, 0, 1, 0, 1);
    idle(8);
    idle($urandom_range(0, 5));
    step(0, 0, 1, 1, 3);
    step(0, 1, 0, 0, 0);
    check_eq("sync_busy", 32'(cfg_busy), 0);
    bad_align = 0; t0_cnt = 0; t1_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 0, 0, 0);
      t0_cnt += int'(tick[0]);
      t1_cnt += int'(tick[1]);
      if (tick[1] && !tick[0]) bad_align++;
    end
    check_eq("sync_misalign", bad_align, 0);
    check_eq("sync_tick0_cnt", t0_cnt, 8);
    check_eq("sync_tick1_cnt", t1_cnt, 4);

    // P=0: tick stays high, clk_out toggles every edge.
    step(0, 0, 1, 0, 0);
    wait_tick(0, 10, n);
    t0_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 0, 0);
      t0_cnt += int'(tick[0]);
    end
    check_eq("p0_tick_cnt", t0_cnt, 6);

    // Channel 3 does not exist: ignored.
    step(0, 0, 1, 3, 1);
    check_eq("bad_ch_busy", 32'(cfg_busy), 0);
    idle(6);

    // clr while an update is pending.
    guard = 0;
    while (t_m + 1 == nxt_m[1] && guard < 4) begin
      step(0, 0, 0, 0, 0);
      guard++;
    end
    step(0, 0, 1, 1, 100);
    check_eq("clr_pre_busy", 32'(cfg_busy[1]), 1);
    step(1, 0, 0, 0, 0);
    check_eq("clr_busy", 32'(cfg_busy), 0);
    wait_tick(1, 30, n);
    check_eq("clr_rst_period", n, 12);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 3), $urandom_range(0, 15));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
